// File: rtl/mem2axi_bridge_if.sv
// AXI4 bus bundle for the bridge's master port.
// Carries the AW, W, B, AR and R channels. Master drives requests and
// ready for responses; Slave is the mirror view.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/mem2axi_bridge.sv
// req/gnt memory port to single-beat AXI4 master, one transaction in flight.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i / gnt_o          request handshake; gnt_o only asserts in IDLE
//   we_i, addr_i, be_i,    request payload (write flag, byte address,
//   wdata_i                byte enables, write data)
//   rvalid_o, rdata_o,     one-cycle response pulse with read data / error
//   err_o
//   mst                    AXI4 master port
module mem2axi_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    AXI_BUS.Master                      mst
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned BEAT_SIZE  = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WAIT_B = 3'd2,
        READ   = 3'd3,
        WAIT_R = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic                      aw_done_q, w_done_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [STRB_WIDTH-1:0]     be_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic                      we_q;

    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic aw_hs, w_hs, resp_hs;

    assign aw_hs   = aw_valid & mst.aw_ready;
    assign w_hs    = w_valid & mst.w_ready;
    assign resp_hs = (state_q == WAIT_B && mst.b_valid) ||
                     (state_q == WAIT_R && mst.r_valid);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = we_i ? WRITE : READ;
            WRITE:   if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = WAIT_B;
            WAIT_B:  if (mst.b_valid) state_d = IDLE;
            READ:    if (mst.ar_ready) state_d = WAIT_R;
            WAIT_R:  if (mst.r_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; valids come only from registered state and done flags
    always_comb begin
        gnt_o    = 1'b0;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        ar_valid = 1'b0;
        b_ready  = 1'b0;
        r_ready  = 1'b0;
        case (state_q)
            IDLE:   gnt_o = req_i;
            WRITE: begin
                aw_valid = ~aw_done_q;
                w_valid  = ~w_done_q;
            end
            WAIT_B: b_ready  = 1'b1;
            READ:   ar_valid = 1'b1;
            WAIT_R: r_ready  = 1'b1;
            default: ;
        endcase
    end

    // Per-channel completion flags for the write address/data phases
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == WRITE) begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
        end else begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end
    end

    // Request payload captured at grant, held stable for the AXI phases
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (gnt_o) begin
            addr_q  <= addr_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            we_q    <= we_i;
        end
    end

    // Response capture; a missing r_last on a single beat counts as an error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= resp_hs;
            if (resp_hs) begin
                rdata_o <= we_q ? '0 : mst.r_data;
                err_o   <= we_q ? mst.b_resp[1] : (mst.r_resp[1] | ~mst.r_last);
            end
        end
    end

    assign mst.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign mst.aw_addr   = addr_q;
    assign mst.aw_len    = 8'd0;
    assign mst.aw_size   = 3'(BEAT_SIZE);
    assign mst.aw_burst  = 2'b01;
    assign mst.aw_lock   = 1'b0;
    assign mst.aw_cache  = 4'd0;
    assign mst.aw_prot   = 3'd0;
    assign mst.aw_qos    = 4'd0;
    assign mst.aw_region = 4'd0;
    assign mst.aw_atop   = 6'd0;
    assign mst.aw_user   = '0;
    assign mst.aw_valid  = aw_valid;

    assign mst.w_data    = wdata_q;
    assign mst.w_strb    = be_q;
    assign mst.w_last    = 1'b1;
    assign mst.w_user    = '0;
    assign mst.w_valid   = w_valid;

    assign mst.b_ready   = b_ready;

    assign mst.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign mst.ar_addr   = addr_q;
    assign mst.ar_len    = 8'd0;
    assign mst.ar_size   = 3'(BEAT_SIZE);
    assign mst.ar_burst  = 2'b01;
    assign mst.ar_lock   = 1'b0;
    assign mst.ar_cache  = 4'd0;
    assign mst.ar_prot   = 3'd0;
    assign mst.ar_qos    = 4'd0;
    assign mst.ar_region = 4'd0;
    assign mst.ar_user   = '0;
    assign mst.ar_valid  = ar_valid;

    assign mst.r_ready   = r_ready;

    // Response IDs and user bits are intentionally ignored
    logic unused_resp;
    assign unused_resp = ^{mst.b_id, mst.b_user, mst.b_resp[0],
                           mst.r_id, mst.r_user, mst.r_resp[0]};
endmodule
